// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: logical/arithmetic/rotate shifts in both directions, one shamt bit per stage.
// Latency SW cycles, one op per cycle; stages advance into empty or moving successors, so bubbles collapse under stall.
module pipelined_barrel_shifter #(
    parameter  int WIDTH = 32,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    shamt,
    input  logic             dir,
    input  logic [1:0]       kind,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b
);

    logic [SW-1:0]    vld_q;
    logic [WIDTH-1:0] dat_q   [SW];
    logic [SW-1:0]    amt_q   [SW-1];
    logic [1:0]       kind_q  [SW-1];
    logic [SW-2:0]    left_q;
    logic [SW-2:0]    sign_q;

    logic [SW-1:0]    adv;
    logic [SW-1:0]    src_vld;
    logic [SW-1:0]    src_left;
    logic [SW-1:0]    src_sign;
    logic [WIDTH-1:0] src_dat  [SW];
    logic [SW-1:0]    src_amt  [SW];
    logic [1:0]       src_kind [SW];
    logic [WIDTH-1:0] nxt_dat  [SW];

    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input int               n,
        input logic             left,
        input logic [1:0]       knd,
        input logic             sgn
    );
        logic [WIDTH-1:0] r;
        if (left) begin
            r = d << n;
            if (knd == 2'b10) r = r | (d >> (WIDTH - n));
        end else begin
            r = d >> n;
            if (knd == 2'b10)
                r = r | (d << (WIDTH - n));
            else if (knd == 2'b01 && sgn)
                r = r | ~({WIDTH{1'b1}} >> n);
        end
        return r;
    endfunction

    // Advance chain runs back from the consumer so a full pipe frees up the same cycle out_ready rises.
    always_comb begin
        adv[SW-1] = !vld_q[SW-1] || out_ready;
        for (int k = SW - 2; k >= 0; k--) begin
            adv[k] = !vld_q[k] || adv[k+1];
        end
    end

    assign in_ready  = adv[0] || rst;
    assign out_valid = vld_q[SW-1];
    assign b         = dat_q[SW-1];

    // Remaining shift bits are shifted down each stage, so every stage consumes bit 0.
    always_comb begin
        src_vld[0]  = in_valid;
        src_dat[0]  = a;
        src_amt[0]  = shamt;
        src_left[0] = dir;
        src_kind[0] = kind;
        src_sign[0] = a[WIDTH-1];
        for (int k = 1; k < SW; k++) begin
            src_vld[k]  = vld_q[k-1];
            src_dat[k]  = dat_q[k-1];
            src_amt[k]  = amt_q[k-1];
            src_left[k] = left_q[k-1];
            src_kind[k] = kind_q[k-1];
            src_sign[k] = sign_q[k-1];
        end
        for (int k = 0; k < SW; k++) begin
            nxt_dat[k] = src_amt[k][0]
                       ? shift_step(src_dat[k], 1 << k, src_left[k], src_kind[k], src_sign[k])
                       : src_dat[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            left_q <= '0;
            sign_q <= '0;
            for (int k = 0; k < SW; k++) begin
                dat_q[k] <= '0;
            end
            for (int k = 0; k < SW - 1; k++) begin
                amt_q[k]  <= '0;
                kind_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SW; k++) begin
                if (adv[k]) begin
                    vld_q[k] <= src_vld[k];
                    dat_q[k] <= nxt_dat[k];
                end
            end
            for (int k = 0; k < SW - 1; k++) begin
                if (adv[k]) begin
                    amt_q[k]  <= src_amt[k] >> 1;
                    left_q[k] <= src_left[k];
                    kind_q[k] <= src_kind[k];
                    sign_q[k] <= src_sign[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench: four shifter instances (WIDTH 4, 8, 32, 64) share one clock, each with its own stimulus and monitor.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   done   = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk(input int w, input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL w%0d %s: got 0x%0h expected 0x%0h", w, name, act, exp);
        end
    endfunction

    // Directed vectors from hand-worked results; w selects the instance width.
    function automatic bit dir_op(input int i, output int w, output logic [63:0] av, output int s,
                                  output logic l, output logic [1:0] k, output logic [63:0] ex);
        bit v = 1'b1;
        w = 0; av = '0; s = 0; l = 1'b0; k = 2'b00; ex = '0;
        case (i)
            0:  begin w = 32; av = 64'h80000001; s = 1;  l = 0; k = 2'b00; ex = 64'h40000000; end
            1:  begin w = 32; av = 64'h80000000; s = 4;  l = 0; k = 2'b01; ex = 64'hF8000000; end
            2:  begin w = 32; av = 64'h00000001; s = 1;  l = 0; k = 2'b10; ex = 64'h80000000; end
            3:  begin w = 32; av = 64'h80000000; s = 4;  l = 1; k = 2'b10; ex = 64'h00000008; end
            4:  begin w = 32; av = 64'hFFFFFFFF; s = 31; l = 1; k = 2'b00; ex = 64'h80000000; end
            5:  begin w = 32; av = 64'h7FFFFFFF; s = 31; l = 0; k = 2'b01; ex = 64'h00000000; end
            6:  begin w = 32; av = 64'hDEADBEEF; s = 8;  l = 0; k = 2'b11; ex = 64'h00DEADBE; end
            7:  begin w = 32; av = 64'hDEADBEEF; s = 8;  l = 0; k = 2'b00; ex = 64'h00DEADBE; end
            8:  begin w = 4;  av = 64'h9;        s = 1;  l = 0; k = 2'b10; ex = 64'hC; end
            9:  begin w = 4;  av = 64'h8;        s = 3;  l = 0; k = 2'b01; ex = 64'hF; end
            10: begin w = 8;  av = 64'h81;       s = 1;  l = 1; k = 2'b10; ex = 64'h03; end
            11: begin w = 8;  av = 64'hF0;       s = 3;  l = 1; k = 2'b01; ex = 64'h80; end
            12: begin w = 64; av = 64'h8000000000000000; s = 63; l = 0; k = 2'b01; ex = 64'hFFFFFFFFFFFFFFFF; end
            13: begin w = 64; av = 64'h0000000000000001; s = 63; l = 1; k = 2'b10; ex = 64'h8000000000000000; end
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_w
        localparam int W = (gi == 0) ? 4 : (gi == 1) ? 8 : (gi == 2) ? 32 : 64;
        localparam int S = $clog2(W);

        logic         rst, in_valid, in_ready, dir, out_valid, out_ready;
        logic [W-1:0] a, b;
        logic [S-1:0] shamt;
        logic [1:0]   kind;
        logic [W-1:0] q_exp [$];
        int           q_due [$];
        bit           rnd_or;

        pipelined_barrel_shifter #(.WIDTH(W)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .shamt(shamt), .dir(dir), .kind(kind),
            .out_valid(out_valid), .out_ready(out_ready), .b(b)
        );

        function automatic logic [W-1:0] rnd();
            return W'({$urandom(), $urandom()});
        endfunction

        // Reference: one whole shift by s, straight from the operation definitions.
        function automatic logic [W-1:0] ref_shift(input logic [W-1:0] x, input int s,
                                                   input logic l, input logic [1:0] k);
            logic [W-1:0] r;
            if (s == 0)            r = x;
            else if (k == 2'b10)   r = l ? ((x << s) | (x >> (W - s))) : ((x >> s) | (x << (W - s)));
            else if (l)            r = x << s;
            else if (k == 2'b01)   r = $signed(x) >>> s;
            else                   r = x >> s;
            return r;
        endfunction

        task automatic tick();
            @(posedge clk);
            #1;
            if (rnd_or) out_ready = ($urandom_range(0, 9) < 7);
        endtask

        task automatic send(input logic [W-1:0] av, input int s, input logic l,
                            input logic [1:0] k, input logic [W-1:0] ex, input bit timed);
            bit ok = 1'b0;
            a = av; shamt = s[S-1:0]; dir = l; kind = k; in_valid = 1'b1;
            for (int t = 0; t < 400 && !ok; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    q_exp.push_back(ex);
                    q_due.push_back(timed ? cyc + S : -1);
                    ok = 1'b1;
                end
                tick();
            end
            in_valid = 1'b0;
            if (!ok) chk(W, 1'b0, "accept timeout", 64'd0, 64'd1);
        endtask

        task automatic wait_drain();
            rnd_or = 1'b0;
            out_ready = 1'b1;
            for (int t = 0; t < 1000 && q_exp.size() > 0; t++) tick();
            chk(W, q_exp.size() == 0, "drain", 64'(q_exp.size()), 64'd0);
        endtask

        initial forever begin
            logic [W-1:0] ev;
            int           due;
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    chk(W, 1'b0, "unexpected result", 64'(b), 64'd0);
                end else begin
                    ev  = q_exp.pop_front();
                    due = q_due.pop_front();
                    chk(W, b == ev, "result", 64'(b), 64'(ev));
                    if (due >= 0) chk(W, cyc == due, "latency", 64'(cyc), 64'(due));
                end
            end
        end

        initial begin
            int           n, w, s;
            bit           full;
            logic [63:0]  av64, ex64;
            logic [63:0]  dbe = 64'hDEADBEEF_DEADBEEF;
            logic [W-1:0] av;
            logic         l;
            logic [1:0]   k;

            rst = 1'b1; in_valid = 1'b1; a = rnd(); shamt = '1; dir = 1'b0; kind = 2'b00;
            out_ready = 1'b0; rnd_or = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk(W, in_ready == 1'b1, "in_ready during reset", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            rst = 1'b0; in_valid = 1'b0;
            @(negedge clk);
            chk(W, out_valid == 1'b0, "reset out_valid", 64'(out_valid), 64'd0);
            chk(W, b == '0, "reset b", 64'(b), 64'd0);
            chk(W, in_ready == 1'b1, "reset in_ready", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
            repeat (S + 3) tick();

            for (int i = 0; i < 16; i++) begin
                if (dir_op(i, w, av64, s, l, k, ex64) && w == W)
                    send(av64[W-1:0], s, l, k, ex64[W-1:0], 1'b1);
            end
            for (int i = 0; i < 8; i++) begin
                send(dbe[W-1:0], 0, 1'(i & 1), 2'(i >> 1), dbe[W-1:0], 1'b1);
            end
            wait_drain();

            out_ready = 1'b0;
            n = 0; full = 1'b0;
            while (n < 8 && !full) begin
                av = rnd(); s = int'($urandom_range(0, W - 1));
                l = 1'($urandom_range(0, 1)); k = 2'($urandom_range(0, 3));
                a = av; shamt = s[S-1:0]; dir = l; kind = k; in_valid = 1'b1;
                @(negedge clk);
                if (in_ready) begin
                    q_exp.push_back(ref_shift(av, s, l, k));
                    q_due.push_back(-1);
                    n++;
                end else begin
                    full = 1'b1;
                end
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            chk(W, n == S, "accepts before stall", 64'(n), 64'(S));
            repeat (3) begin
                @(negedge clk);
                chk(W, out_valid && b == q_exp[0], "stalled output hold", 64'(b), 64'(q_exp[0]));
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk(W, in_ready == 1'b1, "in_ready on release", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            for (int i = n; i < 8; i++) begin
                av = rnd(); s = int'($urandom_range(0, W - 1));
                l = 1'($urandom_range(0, 1)); k = 2'($urandom_range(0, 3));
                send(av, s, l, k, ref_shift(av, s, l, k), 1'b0);
            end
            wait_drain();

            out_ready = 1'b0;
            n = 0; full = 1'b0;
            while (n < 3 && !full) begin
                av = rnd(); a = av; shamt = S'($urandom_range(0, W - 1)); in_valid = 1'b1;
                @(negedge clk);
                if (in_ready) begin
                    q_exp.push_back(av);
                    q_due.push_back(-1);
                    n++;
                end else begin
                    full = 1'b1;
                end
                @(posedge clk); #1;
            end
            a = rnd(); in_valid = 1'b1; rst = 1'b1;
            @(negedge clk);
            chk(W, in_ready == 1'b1, "in_ready in mid reset", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            q_exp.delete(); q_due.delete();
            rst = 1'b0; in_valid = 1'b0;
            @(negedge clk);
            chk(W, out_valid == 1'b0, "mid reset out_valid", 64'(out_valid), 64'd0);
            chk(W, b == '0, "mid reset b", 64'(b), 64'd0);
            chk(W, in_ready == 1'b1, "mid reset in_ready", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
            repeat (S + 4) tick();

            rnd_or = 1'b1;
            for (int i = 0; i < 10000; i++) begin
                av = rnd(); s = int'($urandom_range(0, W - 1));
                l = 1'($urandom_range(0, 1)); k = 2'($urandom_range(0, 3));
                send(av, s, l, k, ref_shift(av, s, l, k), 1'b0);
                if ($urandom_range(0, 1) == 1) tick();
            end
            wait_drain();
            done++;
        end
    end

    initial begin
        while (done < 4 && cyc < 90000) @(posedge clk);
        if (done < 4) chk(0, 1'b0, "global timeout", 64'(done), 64'd4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
